// File: rtl/ram_bank_mc.sv
// Multi-bank RAM with valid/ready write and read ports, post-reset clear engine and
// configurable read latency. Define RAM_BANK_PARITY_EN to store and check a parity bit per word.
module ram_bank_mc #(
    parameter int unsigned ADDR_BIT   = 6,
    parameter int unsigned DATA_BIT   = 16,
    parameter int unsigned MEM_HEIGHT = 64,
    parameter int unsigned NUM_BANK   = 4,
    parameter int unsigned BANK_BIT   = 2,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                init_busy,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [BANK_BIT-1:0] wr_bank,
    input  logic [ADDR_BIT-1:0] wr_addr,
    input  logic [DATA_BIT-1:0] wr_data,
    input  logic                wr_perr_inj,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [BANK_BIT-1:0] rd_bank,
    input  logic [ADDR_BIT-1:0] rd_addr,
    output logic                rsp_valid,
    output logic [DATA_BIT-1:0] rsp_data,
    output logic                rsp_perr
);

    localparam int unsigned IDX_W  = (MEM_HEIGHT > 1) ? $clog2(MEM_HEIGHT) : 1;
    localparam int unsigned BIDX_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
`ifdef RAM_BANK_PARITY_EN
    localparam int unsigned WORD_W = DATA_BIT + 1;
`else
    localparam int unsigned WORD_W = DATA_BIT;
`endif
    localparam logic [ADDR_BIT-1:0] LAST_WORD = ADDR_BIT'(MEM_HEIGHT - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d;

    logic [WORD_W-1:0]   mem [NUM_BANK][MEM_HEIGHT];
    logic [WORD_W-1:0]   wr_word;
    logic                wr_hit, rd_hit, wr_fire, rd_fire;

    logic                rq_valid, rq_hit;
    logic [BIDX_W-1:0]   rq_bank;
    logic [IDX_W-1:0]    rq_addr;
    logic [WORD_W-1:0]   rd_word;
    logic [DATA_BIT-1:0] data_c;
    logic                perr_c;

    logic                s1_valid, s1_perr;
    logic [DATA_BIT-1:0] s1_data;

    // Init/run state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sweep: one word per cycle in all banks, then hand over to traffic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_BIT'(1);
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign wr_ready  = (state_q == ST_RUN) && en;
    assign rd_ready  = (state_q == ST_RUN) && en;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign wr_hit    = (32'(wr_addr) < MEM_HEIGHT) && (32'(wr_bank) < NUM_BANK);
    assign rd_hit    = (32'(rd_addr) < MEM_HEIGHT) && (32'(rd_bank) < NUM_BANK);

`ifdef RAM_BANK_PARITY_EN
    assign wr_word = {(^wr_data) ^ wr_perr_inj, wr_data};
`else
    logic unused_perr_inj;
    assign unused_perr_inj = wr_perr_inj;
    assign wr_word         = wr_data;
`endif

    // Storage; out-of-range writes are silently dropped
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                mem[BIDX_W'(b)][IDX_W'(cnt_q)] <= '0;
            end
        end else if (wr_fire && wr_hit) begin
            mem[BIDX_W'(wr_bank)][IDX_W'(wr_addr)] <= wr_word;
        end
    end

    // Request stage: array is read a cycle later, so a same-edge write is already committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_valid <= 1'b0;
            rq_hit   <= 1'b0;
            rq_bank  <= '0;
            rq_addr  <= '0;
        end else begin
            rq_valid <= rd_fire;
            if (rd_fire) begin
                rq_hit  <= rd_hit;
                rq_bank <= BIDX_W'(rd_bank);
                rq_addr <= IDX_W'(rd_addr);
            end
        end
    end

    assign rd_word = mem[rq_bank][rq_addr];
    assign data_c  = rq_hit ? rd_word[DATA_BIT-1:0] : '0;
`ifdef RAM_BANK_PARITY_EN
    assign perr_c  = rq_hit && ((^rd_word[DATA_BIT-1:0]) != rd_word[DATA_BIT]);
`else
    assign perr_c  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_perr  <= 1'b0;
        end else begin
            s1_valid <= rq_valid;
            if (rq_valid) begin
                s1_data <= data_c;
                s1_perr <= perr_c;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                s2_valid, s2_perr;
            logic [DATA_BIT-1:0] s2_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_perr  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_data  <= s1_data;
                    s2_perr  <= s1_perr;
                end
            end
            assign rsp_valid = s2_valid;
            assign rsp_data  = s2_data;
            assign rsp_perr  = s2_perr;
        end else begin : g_no_out_reg
            assign rsp_valid = s1_valid;
            assign rsp_data  = s1_data;
            assign rsp_perr  = s1_perr;
        end
    endgenerate

endmodule

// File: tb/tb_ram_bank_mc.sv
// Directed bench for ram_bank_mc: vector table plus hand sequences for init, streaming and reset.
module tb_ram_bank_mc;

    // ADDR_BIT widened to 7 so that address 70 (beyond MEM_HEIGHT) is representable
    localparam int unsigned ADDR_BIT   = 7;
    localparam int unsigned DATA_BIT   = 16;
    localparam int unsigned MEM_HEIGHT = 64;
    localparam int unsigned NUM_BANK   = 4;
    localparam int unsigned BANK_BIT   = 2;
    localparam int unsigned OUT_REG    = 0;
    localparam int unsigned LAT        = 1 + OUT_REG;
`ifdef RAM_BANK_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n, en, init_busy;
    logic                wr_valid, wr_ready, wr_perr_inj;
    logic [BANK_BIT-1:0] wr_bank;
    logic [ADDR_BIT-1:0] wr_addr;
    logic [DATA_BIT-1:0] wr_data;
    logic                rd_valid, rd_ready;
    logic [BANK_BIT-1:0] rd_bank;
    logic [ADDR_BIT-1:0] rd_addr;
    logic                rsp_valid, rsp_perr;
    logic [DATA_BIT-1:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    ram_bank_mc #(
        .ADDR_BIT(ADDR_BIT), .DATA_BIT(DATA_BIT), .MEM_HEIGHT(MEM_HEIGHT),
        .NUM_BANK(NUM_BANK), .BANK_BIT(BANK_BIT), .OUT_REG(OUT_REG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .init_busy(init_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_perr_inj(wr_perr_inj),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_perr(rsp_perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                we;
        logic [BANK_BIT-1:0] wb;
        logic [ADDR_BIT-1:0] wa;
        logic [DATA_BIT-1:0] wd;
        logic                inj;
        logic                re;
        logic [BANK_BIT-1:0] rb;
        logic [ADDR_BIT-1:0] ra;
        logic [DATA_BIT-1:0] exp_d;
        logic                exp_p;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid    = 1'b0;
        rd_valid    = 1'b0;
        wr_perr_inj = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_init_busy"}, 32'(init_busy), 32'd1);
        chk({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
        chk({tag, "_rd_ready"},  32'(rd_ready),  32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_perr"},  32'(rsp_perr),  32'd0);
    endtask

    // Counts edges from release until rd_ready rises; flags any response seen meanwhile
    task automatic wait_init(output int n, output logic seen_rsp);
        n = 0;
        seen_rsp = 1'b0;
        while (n < 200) begin
            step();
            n++;
            if (rsp_valid) seen_rsp = 1'b1;
            if (rd_ready) break;
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        chk($sformatf("v%0d_ready", idx), 32'(wr_ready && rd_ready), 32'd1);
        wr_valid = v.we; wr_bank = v.wb; wr_addr = v.wa; wr_data = v.wd; wr_perr_inj = v.inj;
        rd_valid = v.re; rd_bank = v.rb; rd_addr = v.ra;
        step();
        idle();
        if (v.re) begin
            chk($sformatf("v%0d_early", idx), 32'(rsp_valid), 32'd0);
            repeat (LAT) step();
            chk($sformatf("v%0d_valid", idx), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_data", idx),  32'(rsp_data),  32'(v.exp_d));
            chk($sformatf("v%0d_perr", idx),  32'(rsp_perr),  32'(v.exp_p));
            step();
            chk($sformatf("v%0d_pulse", idx), 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int             n;
        logic           seen;
        logic [DATA_BIT-1:0] got [$];

        //           we    wb    wa     wd        inj   re    rb    ra     exp_d     exp_p
        vecs[0]  = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd3, 7'd63, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 7'd10, 16'hA5A5, 1'b0, 1'b0, 2'd0, 7'd0,  16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd1, 7'd10, 16'hA5A5, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd2, 7'd10, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 7'd5,  16'hFFFF, 1'b0, 1'b0, 2'd0, 7'd0,  16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 7'd5,  16'h1234, 1'b0, 1'b1, 2'd0, 7'd5,  16'h1234, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 7'd5,  16'hFFFF, 1'b0, 1'b0, 2'd0, 7'd0,  16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 7'd5,  16'h1234, 1'b0, 1'b1, 2'd0, 7'd5,  16'hFFFF, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd1, 7'd5,  16'h1234, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 7'd70, 16'hBEEF, 1'b0, 1'b1, 2'd2, 7'd70, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd2, 7'd6,  16'h0000, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd0, 7'd6,  16'h0000, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd1, 7'd10, 16'hA5A5, 1'b0};
        vecs[13] = '{1'b1, 2'd3, 7'd1,  16'h0001, 1'b1, 1'b0, 2'd0, 7'd0,  16'h0000, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 7'd0,  16'h0000, 1'b0, 1'b1, 2'd3, 7'd1,  16'h0001, PAR_EN};
        vecs[15] = '{1'b1, 2'd3, 7'd2,  16'h0007, 1'b0, 1'b1, 2'd3, 7'd2,  16'h0007, 1'b0};

        rst_n = 1'b0; en = 1'b1;
        wr_bank = '0; wr_addr = '0; wr_data = '0;
        rd_bank = '0; rd_addr = '0;
        idle();
        repeat (3) step();
        chk_reset_vals("por");

        rst_n = 1'b1;
        wait_init(n, seen);
        chk("por_init_cycles", 32'(n), 32'd64);
        chk("por_init_busy_low", 32'(init_busy), 32'd0);

        for (int i = 0; i < 16; i++) apply_vec(vecs[i], i);

        // Streaming reads with en dropping at cycle 4
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_bank = 2'd0; wr_addr = ADDR_BIT'(i); wr_data = 16'h1000 + 16'(i);
            step();
        end
        idle();
        rd_bank = 2'd0;
        for (int c = 0; c < 8 + 2 * LAT + 2; c++) begin
            rd_valid = (c < 8);
            rd_addr  = ADDR_BIT'(c % 8);
            en       = (c < 4);
            if (c == 5) chk("stream_rd_ready_off", 32'(rd_ready), 32'd0);
            step();
            if (rsp_valid) got.push_back(rsp_data);
        end
        idle();
        en = 1'b1;
        chk("stream_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk($sformatf("stream_rsp%0d", i), 32'(got[i]), 32'h1000 + 32'(i));
        end

        // Asynchronous reset while responses are streaming
        rd_valid = 1'b1; rd_bank = 2'd1; rd_addr = 7'd10;
        repeat (3) step();
        chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        chk_reset_vals("mid_async");
        step();
        chk_reset_vals("mid_held");
        rst_n = 1'b1;
        wait_init(n, seen);
        chk("mid_init_cycles", 32'(n), 32'd64);
        chk("mid_no_stale_rsp", 32'(seen), 32'd0);
        apply_vec('{1'b0, 2'd0, 7'd0, 16'h0000, 1'b0, 1'b1, 2'd1, 7'd10, 16'h0000, 1'b0}, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
